dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_picker.sv | 21 ++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int ID_W = 1;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - two-way winner selection, round-robin or fixed priority
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [1:0]      req,
    input  logic            ptr,
    input  logic            fixed,
    output logic [ID_W-1:0] winner
);

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        winner = '0;
        if (req == 2'b11) begin
            winner = fixed ? 1'b0 : ptr;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for a single-port synchronous data memory
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 8,
    parameter int DW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t      state, state_n;
    logic            ptr;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] win;
    logic [DW-1:0]   r0_hold;
    logic [DW-1:0]   r1_hold;

    rr_picker u_picker (
        .req    ({r1_req, r0_req}),
        .ptr    (ptr),
        .fixed  (FIXED_PRIO != 0),
        .winner (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (r0_req || r1_req) state_n = ISSUE;
            ISSUE:   state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The memory port is driven only for the single ISSUE cycle of an access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= 1'b0;
            win       <= '0;
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_hold   <= '0;
            r1_hold   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        win <= pick;
                        if (FIXED_PRIO == 0) ptr <= ~pick;
                        if (pick == 1'b0) begin
                            r0_gnt    <= 1'b1;
                            mem_we    <= r0_we;
                            mem_addr  <= r0_addr;
                            mem_wdata <= r0_wdata;
                        end else begin
                            r1_gnt    <= 1'b1;
                            mem_we    <= r1_we;
                            mem_addr  <= r1_addr;
                            mem_wdata <= r1_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (win == 1'b0) r0_rvalid <= 1'b1;
                    else             r1_rvalid <= 1'b1;
                end
                RESP: begin
                    if (r0_rvalid) r0_hold <= mem_rdata;
                    if (r1_rvalid) r1_hold <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Memory read data is already registered, so it is forwarded during RESP and held afterwards.
    assign r0_rdata = r0_rvalid ? mem_rdata : r0_hold;
    assign r1_rdata = r1_rvalid ? mem_rdata : r1_hold;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for round-robin and fixed-priority arbiters
module tb_dmem_arbiter;

    logic       clk;
    logic       rst;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

    logic       a_g0, a_g1, a_v0, a_v1, a_mwe, a_busy;
    logic [7:0] a_d0, a_d1, a_maddr, a_mwdata, a_mrdata;
    logic       b_g0, b_g1, b_v0, b_v1, b_mwe, b_busy;
    logic [7:0] b_d0, b_d1, b_maddr, b_mwdata, b_mrdata;

    logic       pl_en;
    logic [7:0] pl_addr, pl_data;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.FIXED_PRIO(0), .AW(8), .DW(8)) dut_rr (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(a_g0), .r0_rvalid(a_v0), .r0_rdata(a_d0),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(a_g1), .r1_rvalid(a_v1), .r1_rdata(a_d1),
        .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata),
        .busy(a_busy)
    );

    dmem_arbiter #(.FIXED_PRIO(1), .AW(8), .DW(8)) dut_fx (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(b_g0), .r0_rvalid(b_v0), .r0_rdata(b_d0),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(b_g1), .r1_rvalid(b_v1), .r1_rdata(b_d1),
        .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (a_mwe) mem_a[a_maddr] <= a_mwdata;
            if (b_mwe) mem_b[b_maddr] <= b_mwdata;
        end
        a_mrdata <= a_mwe ? a_mwdata : mem_a[a_maddr];
        b_mrdata <= b_mwe ? b_mwdata : mem_b[b_maddr];
    end

    typedef struct {
        logic       q0, w0;
        logic [7:0] ad0, wd0;
        logic       q1, w1;
        logic [7:0] ad1, wd1;
        logic       g0, g1, v0, v1;
        logic [7:0] d0, d1;
        logic       mwe;
        logic [7:0] maddr;
        logic       busy;
        logic       fg0, fg1;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(
        input logic q0, input logic w0, input logic [7:0] ad0, input logic [7:0] wd0,
        input logic q1, input logic w1, input logic [7:0] ad1, input logic [7:0] wd1,
        input logic g0, input logic g1, input logic v0, input logic v1,
        input logic [7:0] d0, input logic [7:0] d1, input logic mwe, input logic [7:0] maddr,
        input logic busy, input logic fg0, input logic fg1);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.ad0 = ad0; v.wd0 = wd0;
        v.q1 = q1; v.w1 = w1; v.ad1 = ad1; v.wd1 = wd1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.d0 = d0; v.d1 = d1; v.mwe = mwe; v.maddr = maddr;
        v.busy = busy; v.fg0 = fg0; v.fg1 = fg1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic protocol();
        chk("mon_rr_dual_gnt",    8'(a_g0 & a_g1), 8'd0);
        chk("mon_rr_dual_rvalid", 8'(a_v0 & a_v1), 8'd0);
        chk("mon_rr_we_outside",  8'(a_mwe & ~(a_g0 | a_g1)), 8'd0);
        chk("mon_fx_dual_gnt",    8'(b_g0 & b_g1), 8'd0);
        chk("mon_fx_dual_rvalid", 8'(b_v0 & b_v1), 8'd0);
        chk("mon_fx_we_outside",  8'(b_mwe & ~(b_g0 | b_g1)), 8'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) protocol();
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [7:0] ad0, input logic [7:0] wd0,
                         input logic q1, input logic w1, input logic [7:0] ad1, input logic [7:0] wd1);
        r0_req = q0; r0_we = w0; r0_addr = ad0; r0_wdata = wd0;
        r1_req = q1; r1_we = w1; r1_addr = ad1; r1_wdata = wd1;
    endtask

    initial begin
        rst = 1'b0;
        pl_en = 1'b1; pl_addr = 8'h10; pl_data = 8'hA5;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        //        q0 w0 ad0    wd0    q1 w1 ad1    wd1    g0 g1 v0 v1 d0     d1     mwe maddr busy fg0 fg1
        vecs[0]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h10, 1, 1, 0);
        vecs[1]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h00, 0, 8'h00, 1, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00, 0, 8'h00, 0, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1, 0, 0, 8'hA5, 8'h00, 1, 8'h20, 1, 0, 1);
        vecs[4]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h3C, 0, 8'h00, 1, 0, 0);
        vecs[5]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0, 0, 8'hA5, 8'h3C, 0, 8'h20, 1, 0, 1);
        vecs[7]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h3C, 0, 8'h00, 1, 0, 0);
        vecs[8]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h00, 0, 0, 0);
        vecs[9]  = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h10, 1, 1, 0);
        vecs[10] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h3C, 0, 8'h00, 1, 0, 0);
        vecs[11] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h00, 0, 0, 0);
        vecs[12] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0, 0, 8'hA5, 8'h3C, 0, 8'h20, 1, 1, 0);
        vecs[13] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h3C, 0, 8'h00, 1, 0, 0);
        vecs[14] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h00, 0, 0, 0);
        vecs[15] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h10, 1, 1, 0);
        vecs[16] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 1, 0, 8'hA5, 8'h3C, 0, 8'h00, 1, 0, 0);
        vecs[17] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h00, 0, 0, 0);
        vecs[18] = mk(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0, 0, 8'hA5, 8'h3C, 0, 8'h20, 1, 1, 0);
        vecs[19] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h3C, 0, 8'h00, 1, 0, 0);
        vecs[20] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h3C, 0, 8'h00, 0, 0, 0);

        repeat (3) step();
        chk("reset_rr_gnt",    8'({a_g0, a_g1}), 8'd0);
        chk("reset_rr_rvalid", 8'({a_v0, a_v1}), 8'd0);
        chk("reset_rr_rdata0", a_d0, 8'h00);
        chk("reset_rr_memwe",  8'(a_mwe), 8'd0);
        chk("reset_rr_busy",   8'(a_busy), 8'd0);
        chk("reset_fx_busy",   8'(b_busy), 8'd0);
        pl_en = 1'b0;
        rst = 1'b1;
        step();
        chk("idle_after_release_busy", 8'(a_busy), 8'd0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].q0, vecs[i].w0, vecs[i].ad0, vecs[i].wd0,
                  vecs[i].q1, vecs[i].w1, vecs[i].ad1, vecs[i].wd1);
            step();
            chk($sformatf("v%0d_rr_r0_gnt", i),    8'(a_g0),  8'(vecs[i].g0));
            chk($sformatf("v%0d_rr_r1_gnt", i),    8'(a_g1),  8'(vecs[i].g1));
            chk($sformatf("v%0d_rr_r0_rvalid", i), 8'(a_v0),  8'(vecs[i].v0));
            chk($sformatf("v%0d_rr_r1_rvalid", i), 8'(a_v1),  8'(vecs[i].v1));
            chk($sformatf("v%0d_rr_r0_rdata", i),  a_d0,      vecs[i].d0);
            chk($sformatf("v%0d_rr_r1_rdata", i),  a_d1,      vecs[i].d1);
            chk($sformatf("v%0d_rr_mem_we", i),    8'(a_mwe), 8'(vecs[i].mwe));
            chk($sformatf("v%0d_rr_mem_addr", i),  a_maddr,   vecs[i].maddr);
            chk($sformatf("v%0d_rr_busy", i),      8'(a_busy), 8'(vecs[i].busy));
            chk($sformatf("v%0d_fx_r0_gnt", i),    8'(b_g0),  8'(vecs[i].fg0));
            chk($sformatf("v%0d_fx_r1_gnt", i),    8'(b_g1),  8'(vecs[i].fg1));
        end
        chk("rr_write_data_on_port", a_mwdata, 8'h00);

        // Reset in the ISSUE cycle of an r0 read must kill the access.
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        chk("rst_mid_issue_r0_gnt", 8'(a_g0), 8'd1);
        chk("rst_mid_issue_addr",   a_maddr, 8'h10);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_r0_gnt",  8'(a_g0), 8'd0);
        chk("rst_async_busy",    8'(a_busy), 8'd0);
        chk("rst_async_addr",    a_maddr, 8'h00);
        chk("rst_async_r0_rdata", a_d0, 8'h00);
        chk("rst_async_fx_gnt",  8'(b_g0), 8'd0);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        chk("rst_no_r0_rvalid", 8'(a_v0), 8'd0);
        chk("rst_no_busy",      8'(a_busy), 8'd0);
        rst = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        step();
        chk("post_rst_r1_gnt",  8'(a_g1), 8'd1);
        chk("post_rst_r0_gnt",  8'(a_g0), 8'd0);
        chk("post_rst_addr",    a_maddr, 8'h20);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        chk("post_rst_r1_rvalid", 8'(a_v1), 8'd1);
        chk("post_rst_r1_rdata",  a_d1, 8'h3C);
        chk("post_rst_r0_rvalid", 8'(a_v0), 8'd0);
        step();
        chk("post_rst_r1_hold",   a_d1, 8'h3C);
        chk("post_rst_idle",      8'(a_busy), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
